posit_decoder_n: RTL and testbench

Parametrised multi-cycle posit decoder: accepts an N-bit posit word with ES exponent bits on a start/done handshake and produces sign, regime k, exponent, hidden-bit mantissa and combined scale. It also flags zero and NaR and decodes negative posits through two's complement. It sits at the front of the posit arithmetic datapath, ahead of the multiply/add units, and replaces the fixed 32-bit/ES=3 decoder.

---
 rtl/posit_pkg.sv | 45 ++++
 rtl/posit_regime_scanner.sv | 88 ++++++++
 rtl/posit_decoder_n.sv | 195 +++++++++++++++++++
 tb/tb_posit_decoder_n.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// posit_pkg
//   Shared definitions for the posit decoding datapath.
//   - posit_state_t : decoder FSM states (IDLE, PREP, REGIME, EXP, FRAC)
//   - clog2_f       : constant-safe ceiling log2
//   - posit_zero_f  : all-zeros special pattern for an n-bit word
//   - posit_nar_f   : NaR special pattern (1 followed by n-1 zeros)
//   The pattern helpers return POSIT_MAX_N bits; callers truncate to N.
package posit_pkg;

    localparam int POSIT_MAX_N = 128;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREP   = 3'd1,
        ST_REGIME = 3'd2,
        ST_EXP    = 3'd3,
        ST_FRAC   = 3'd4
    } posit_state_t;

    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [POSIT_MAX_N-1:0] posit_zero_f(input int n);
        logic [POSIT_MAX_N-1:0] p;
        p = '0;
        for (int i = 0; i < POSIT_MAX_N; i++) begin
            if (i < n) p[i] = 1'b0;
        end
        return p;
    endfunction

    function automatic logic [POSIT_MAX_N-1:0] posit_nar_f(input int n);
        logic [POSIT_MAX_N-1:0] p;
        p    = '0;
        p[0] = 1'b1;
        return p << (n - 1);
    endfunction

endpackage

// File: rtl/posit_regime_scanner.sv
// posit_regime_scanner
//   Bit-serial front end of the posit decoder. Holds the working shift
//   register, the regime run counter m, the count of still-unconsumed bits
//   and the terminator detect. Bits are consumed from the MSB; zeros are
//   shifted in at the bottom, so any field read past the last valid bit
//   naturally reads as 0.
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   i_load        : capture i_data, clear counters
//   i_data        : posit word to capture
//   i_prep        : optionally negate, drop the sign bit, latch r0
//   i_negate      : with i_prep, replace the word by its two's complement
//   i_shift       : consume one regime bit (no effect when empty)
//   i_exp_shift   : consume ES exponent bits, saturating at empty
//   o_sr          : current shift register contents
//   o_r0          : leading regime bit
//   o_m           : regime run length so far
//   o_empty       : no unconsumed bits remain
//   o_term        : next bit is the regime terminator
module posit_regime_scanner
    import posit_pkg::*;
#(
    parameter int N  = 32,
    parameter int ES = 3,
    parameter int KW = clog2_f(N) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [N-1:0]  i_data,
    input  logic          i_prep,
    input  logic          i_negate,
    input  logic          i_shift,
    input  logic          i_exp_shift,
    output logic [N-1:0]  o_sr,
    output logic          o_r0,
    output logic [KW-1:0] o_m,
    output logic          o_empty,
    output logic          o_term
);

    localparam int RW = clog2_f(N) + 1;

    logic [N-1:0]  r_sr;
    logic          r_r0;
    logic [KW-1:0] r_m;
    logic [RW-1:0] r_rem;

    logic [N-1:0]  w_pos;
    logic          w_empty;

    assign w_pos   = i_negate ? (~r_sr + N'(1)) : r_sr;
    assign w_empty = (r_rem == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr  <= '0;
            r_r0  <= 1'b0;
            r_m   <= '0;
            r_rem <= '0;
        end else if (i_load) begin
            r_sr  <= i_data;
            r_r0  <= 1'b0;
            r_m   <= '0;
            r_rem <= '0;
        end else if (i_prep) begin
            // Sign bit leaves the register; the bit under it becomes r0 and
            // is itself the first bit of the regime run.
            r_sr  <= w_pos << 1;
            r_r0  <= w_pos[N-2];
            r_rem <= RW'(N - 1);
        end else if (i_shift && !w_empty) begin
            r_sr  <= r_sr << 1;
            r_rem <= r_rem - RW'(1);
            if (r_sr[N-1] == r_r0) r_m <= r_m + KW'(1);
        end else if (i_exp_shift) begin
            r_sr  <= r_sr << ES;
            r_rem <= (r_rem > RW'(ES)) ? (r_rem - RW'(ES)) : '0;
        end
    end

    assign o_sr    = r_sr;
    assign o_r0    = r_r0;
    assign o_m     = r_m;
    assign o_empty = w_empty;
    assign o_term  = !w_empty && (r_sr[N-1] != r_r0);

endmodule

// File: rtl/posit_decoder_n.sv
// posit_decoder_n
//   Multi-cycle posit decoder (N-bit word, ES exponent bits).
//   Handshake: start is sampled only while idle; the accepting edge raises
//   busy. done pulses for one cycle with busy already low, and the result
//   fields are valid from that cycle until the next completed decode. A
//   start present during the done cycle is accepted (back-to-back); a start
//   while busy is dropped.
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   start       : decode request
//   posit_num   : posit word, captured on the accepting edge
//   busy, done  : handshake status
//   sign, zero, nar : sign bit and special-value flags
//   k           : signed regime value
//   exp_value   : exponent field (zero-padded past the end of the word)
//   mantissa    : {1, fraction left-aligned}
//   scale       : signed k*2^ES + exp_value
//   dbg_state   : current FSM state
module posit_decoder_n
    import posit_pkg::*;
#(
    parameter int N  = 32,
    parameter int ES = 3,
    parameter int KW = clog2_f(N) + 1,
    localparam int EW = (ES > 0) ? ES : 1,
    localparam int SW = KW + ES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N-1:0]         posit_num,
    output logic                 busy,
    output logic                 done,
    output logic                 sign,
    output logic                 zero,
    output logic                 nar,
    output logic signed [KW-1:0] k,
    output logic [EW-1:0]        exp_value,
    output logic [N-1:0]         mantissa,
    output logic signed [SW-1:0] scale,
    output posit_state_t         dbg_state
);

    localparam logic [N-1:0] ZERO_PAT = N'(posit_zero_f(N));
    localparam logic [N-1:0] NAR_PAT  = N'(posit_nar_f(N));

    posit_state_t       r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_sign;
    logic               r_zero;
    logic               r_nar;
    logic               r_special;
    logic [EW-1:0]      r_exp_tmp;
    logic signed [KW-1:0] r_k;
    logic [EW-1:0]      r_exp;
    logic [N-1:0]       r_mant;
    logic signed [SW-1:0] r_scale;

    logic [N-1:0]       w_sr;
    logic               w_r0;
    logic [KW-1:0]      w_m;
    logic               w_empty;
    logic               w_term;
    logic               w_is_zero;
    logic               w_is_nar;
    logic               w_special;
    logic               w_load;
    logic               w_prep;
    logic               w_shift;
    logic               w_exp_shift;
    logic [EW-1:0]      w_exp_field;
    logic signed [KW-1:0] w_k;
    logic signed [SW-1:0] w_k_ext;
    logic signed [SW-1:0] w_exp_ext;
    logic signed [SW-1:0] w_scale;

    assign w_is_zero = (w_sr == ZERO_PAT);
    assign w_is_nar  = (w_sr == NAR_PAT);
    assign w_special = w_is_zero || w_is_nar;

    assign w_load      = (r_state == ST_IDLE) && start;
    assign w_prep      = (r_state == ST_PREP) && !w_special;
    assign w_shift     = (r_state == ST_REGIME);
    assign w_exp_shift = (r_state == ST_EXP);

    posit_regime_scanner #(
        .N  (N),
        .ES (ES),
        .KW (KW)
    ) u_scanner (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_data      (posit_num),
        .i_prep      (w_prep),
        .i_negate    (w_sr[N-1]),
        .i_shift     (w_shift),
        .i_exp_shift (w_exp_shift),
        .o_sr        (w_sr),
        .o_r0        (w_r0),
        .o_m         (w_m),
        .o_empty     (w_empty),
        .o_term      (w_term)
    );

    // Top ES bits of the register; a shift by N (ES = 0) yields 0.
    assign w_exp_field = EW'(w_sr >> (N - ES));

    assign w_k       = w_r0 ? $signed(w_m - KW'(1)) : $signed(KW'(0) - w_m);
    assign w_k_ext   = SW'(w_k);
    assign w_exp_ext = SW'(r_exp_tmp);
    assign w_scale   = (w_k_ext <<< ES) + w_exp_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sign    <= 1'b0;
            r_zero    <= 1'b0;
            r_nar     <= 1'b0;
            r_special <= 1'b0;
            r_exp_tmp <= '0;
            r_k       <= '0;
            r_exp     <= '0;
            r_mant    <= '0;
            r_scale   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_busy  <= 1'b1;
                        r_zero  <= 1'b0;
                        r_nar   <= 1'b0;
                        r_state <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    r_sign <= w_sr[N-1];
                    if (w_special) begin
                        // Specials skip the scan but still complete through
                        // FRAC, which gives them their two-cycle latency.
                        r_zero    <= w_is_zero;
                        r_nar     <= w_is_nar;
                        r_special <= 1'b1;
                        r_state   <= ST_FRAC;
                    end else begin
                        r_special <= 1'b0;
                        r_state   <= ST_REGIME;
                    end
                end
                ST_REGIME: begin
                    // A terminator is consumed on this edge; an exhausted word
                    // is only noticed one cycle after the last bit went out.
                    if (w_empty || w_term) r_state <= ST_EXP;
                end
                ST_EXP: begin
                    r_exp_tmp <= w_exp_field;
                    r_state   <= ST_FRAC;
                end
                ST_FRAC: begin
                    if (r_special) begin
                        r_k     <= '0;
                        r_exp   <= '0;
                        r_mant  <= '0;
                        r_scale <= '0;
                    end else begin
                        r_k     <= w_k;
                        r_exp   <= r_exp_tmp;
                        r_mant  <= {1'b1, w_sr[N-1:1]};
                        r_scale <= w_scale;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign sign      = r_sign;
    assign zero      = r_zero;
    assign nar       = r_nar;
    assign k         = r_k;
    assign exp_value = r_exp;
    assign mantissa  = r_mant;
    assign scale     = r_scale;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_posit_decoder_n.sv
module tb_posit_decoder_n;
  import posit_pkg::*;

  localparam int N  = 32;
  localparam int ES = 3;

  logic               clk;
  logic               rst;
  logic               start;
  logic [N-1:0]       posit_num;
  logic               busy;
  logic               done;
  logic               sign;
  logic               zero;
  logic               nar;
  logic signed [5:0]  k;
  logic [2:0]         exp_value;
  logic [N-1:0]       mantissa;
  logic signed [8:0]  scale;
  posit_state_t       dbg_state;

  int checks;
  int failures;

  typedef struct {
    int          sign;
    int          zero;
    int          nar;
    int          k;
    int          exp_v;
    logic [31:0] mant;
    int          scale;
    int          lat;
  } ref_t;

  posit_decoder_n #(.N(N), .ES(ES)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .posit_num (posit_num),
    .busy      (busy),
    .done      (done),
    .sign      (sign),
    .zero      (zero),
    .nar       (nar),
    .k         (k),
    .exp_value (exp_value),
    .mantissa  (mantissa),
    .scale     (scale),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: read the posit field by field from the bit string
  function automatic ref_t model(input logic [31:0] w);
    ref_t        e;
    logic [31:0] v;
    logic [30:0] body;
    int          pos;
    int          m;
    int          term;
    int          r0;
    int          j;
    e.sign = 0; e.zero = 0; e.nar = 0; e.k = 0; e.exp_v = 0;
    e.mant = 32'h0; e.scale = 0; e.lat = 2;
    if (w == 32'h0) begin
      e.zero = 1;
      return e;
    end
    if (w == 32'h8000_0000) begin
      e.nar = 1; e.sign = 1;
      return e;
    end
    e.sign = int'(w[31]);
    v = w[31] ? (32'h0 - w) : w;
    body = v[30:0];
    pos = 30;
    r0 = int'(body[30]);
    m = 0;
    while (pos >= 0 && int'(body[pos]) == r0) begin
      m++;
      pos--;
    end
    term = 0;
    if (pos >= 0) begin
      term = 1;
      pos--;
    end
    e.k = (r0 == 1) ? m - 1 : -m;
    e.lat = (term == 1) ? m + 4 : N + 3;
    for (int i = 0; i < ES; i++) begin
      e.exp_v = e.exp_v * 2 + ((pos >= 0) ? int'(body[pos]) : 0);
      pos--;
    end
    e.mant = 32'h8000_0000;
    j = 30;
    while (pos >= 0) begin
      e.mant[j] = body[pos];
      j--;
      pos--;
    end
    e.scale = e.k * (1 << ES) + e.exp_v;
    return e;
  endfunction

  task automatic check_int(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_hex(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_fields(input string tag, input ref_t e);
    check_int({tag, "_sign"}, int'(sign), e.sign);
    check_int({tag, "_zero"}, int'(zero), e.zero);
    check_int({tag, "_nar"}, int'(nar), e.nar);
    check_int({tag, "_k"}, int'(k), e.k);
    check_int({tag, "_exp"}, int'(exp_value), e.exp_v);
    check_hex({tag, "_mant"}, mantissa, e.mant);
    check_int({tag, "_scale"}, int'(scale), e.scale);
    check_int({tag, "_busy_at_done"}, int'(busy), 0);
  endtask

  // wait (bounded) for done, starting 1ns after the accepting edge
  task automatic wait_done(output int lat, output int seen);
    lat = 0;
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1;
    end
  endtask

  // driver: one complete decode with all checks
  task automatic run_decode(input string tag, input logic [31:0] w);
    ref_t e;
    int   lat;
    int   seen;
    e = model(w);
    @(negedge clk);
    start = 1'b1;
    posit_num = w;
    @(posedge clk); #1;
    start = 1'b0;
    check_int({tag, "_busy_accept"}, int'(busy), 1);
    wait_done(lat, seen);
    check_int({tag, "_done_seen"}, seen, 1);
    check_int({tag, "_latency"}, lat, e.lat);
    check_fields(tag, e);
    @(posedge clk); #1;
    check_int({tag, "_done_one_cycle"}, int'(done), 0);
  endtask

  task automatic count_dones(input int cycles, output int n_done, output int n_busy);
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
      if (busy) n_busy++;
    end
  endtask

  initial begin
    ref_t        e;
    int          lat;
    int          seen;
    int          nd;
    int          nb;
    logic [31:0] w;

    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    posit_num = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_done", int'(done), 0);
    check_int("rst_k", int'(k), 0);
    check_hex("rst_mant", mantissa, 32'h0);
    check_int("rst_scale", int'(scale), 0);
    check_int("rst_state", int'(dbg_state), int'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;

    // directed vectors
    run_decode("one", 32'h4000_0000);
    run_decode("exp2", 32'h4A00_0000);
    run_decode("neg_one", 32'hC000_0000);
    run_decode("zero", 32'h0000_0000);
    run_decode("nar", 32'h8000_0000);
    run_decode("maxpos", 32'h7FFF_FFFF);
    run_decode("minpos", 32'h0000_0001);
    run_decode("neg_max", 32'h8000_0001);

    // start pulsed while busy is dropped
    e = model(32'h4000_0000);
    @(negedge clk);
    start = 1'b1;
    posit_num = 32'h4000_0000;
    @(posedge clk); #1;
    start = 1'b0;
    posit_num = 32'h7FFF_FFFF;
    lat = 0;
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1;
      start = (lat == 1 || lat == 2);
    end
    start = 1'b0;
    check_int("busy_ign_done_seen", seen, 1);
    check_int("busy_ign_latency", lat, e.lat);
    check_fields("busy_ign", e);
    count_dones(40, nd, nb);
    check_int("busy_ign_no_extra_done", nd, 0);
    check_int("busy_ign_no_extra_busy", nb, 0);

    // start held through done: back-to-back decodes
    e = model(32'h4A00_0000);
    @(negedge clk);
    start = 1'b1;
    posit_num = 32'h4A00_0000;
    @(posedge clk); #1;
    wait_done(lat, seen);
    check_int("b2b_first_seen", seen, 1);
    check_int("b2b_first_latency", lat, e.lat);
    check_fields("b2b_first", e);
    posit_num = 32'h4000_0000;
    @(posedge clk); #1;
    start = 1'b0;
    check_int("b2b_second_accepted", int'(busy), 1);
    e = model(32'h4000_0000);
    wait_done(lat, seen);
    check_int("b2b_second_seen", seen, 1);
    check_int("b2b_second_latency", lat, e.lat);
    check_fields("b2b_second", e);

    // asynchronous reset in the middle of the regime scan
    @(negedge clk);
    start = 1'b1;
    posit_num = 32'h7FFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_int("midrst_in_regime", int'(dbg_state), int'(ST_REGIME));
    check_int("midrst_busy_before", int'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_int("midrst_busy", int'(busy), 0);
    check_int("midrst_state", int'(dbg_state), int'(ST_IDLE));
    check_hex("midrst_mant", mantissa, 32'h0);
    check_int("midrst_k", int'(k), 0);
    check_int("midrst_scale", int'(scale), 0);
    check_int("midrst_exp", int'(exp_value), 0);
    check_int("midrst_sign", int'(sign), 0);
    @(negedge clk);
    rst = 1'b0;
    count_dones(40, nd, nb);
    check_int("midrst_no_done", nd, 0);
    run_decode("after_rst", 32'h4A00_0000);

    // randomized words, biased toward long regime runs every other step
    for (int i = 0; i < 60; i++) begin
      w = $urandom;
      if (i % 4 == 1) w = w >> $urandom_range(0, 31);
      if (i % 4 == 3) w = ~(w >> $urandom_range(0, 31));
      run_decode("rand", w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
